// File: rtl/iqft3_pipelined_pkg.sv
// iqft3_pipelined_pkg: fixed-point types, gate schedule and per-gate lane math for the inverse QFT.
package iqft3_pipelined_pkg;
  localparam int DATA_W = 8;
  localparam int FRAC_W = 4;
  localparam int INV_SQRT2 = 11;
  localparam int SAT_MAX = 2 ** (DATA_W - 1) - 1;
  localparam int SAT_MIN = -(2 ** (DATA_W - 1));
  localparam int STAGES = 14;
  typedef logic signed [DATA_W-1:0] amp_t;
  typedef logic signed [DATA_W:0] wide_t;
  typedef struct packed { amp_t r; amp_t i; } cpx_t;
  typedef struct packed { wide_t r; wide_t i; } wcpx_t;
  typedef cpx_t [7:0] vec_t;
  typedef wcpx_t [7:0] wvec_t;
  typedef enum logic [1:0] {G_H, G_CP2, G_CP4} gate_e;

  function automatic gate_e gate_op(int g);
    return g == 3 ? G_CP4 : (g == 1 || g == 4) ? G_CP2 : G_H;
  endfunction

  // H: mask of the target qubit; CP: mask of both control bits
  function automatic logic [2:0] gate_mask(int g);
    return g == 0 ? 3'b001 : g == 1 ? 3'b011 : g == 2 ? 3'b010 :
           g == 3 ? 3'b101 : g == 4 ? 3'b110 : 3'b100;
  endfunction

  function automatic logic [2:0] swap_idx(logic [2:0] k);
    return {k[0], k[1], k[2]};
  endfunction

  function automatic wide_t ext(amp_t a);
    return {a[DATA_W-1], a};
  endfunction

  function automatic logic scaled(gate_e op, logic [2:0] m, logic [2:0] k);
    return op == G_H || (op == G_CP4 && (k & m) == m);
  endfunction

  // First sub-cycle of a gate: sums/differences/swaps before the 1/sqrt2 scaling
  function automatic wvec_t rotate(vec_t v, gate_e op, logic [2:0] m);
    wvec_t w;
    logic [2:0] k, p;
    wide_t r, i, ar, ai;
    for (int n = 0; n < 8; n++) begin
      k = 3'(n);
      p = k ^ m;
      r = ext(v[k].r);
      i = ext(v[k].i);
      ar = ext(v[p].r);
      ai = ext(v[p].i);
      w[k] = {r, i};
      if (op == G_H)
        w[k] = (k & m) == 3'b000 ? {r + ar, i + ai} : {ar - r, ai - i};
      else if ((k & m) == m)
        w[k] = op == G_CP2 ? {i, v[k].r == amp_t'(SAT_MIN) ? wide_t'(SAT_MAX) : -r}
                           : {r + i, i - r};
    end
    return w;
  endfunction
endpackage

// File: rtl/fxp_scale_rnd_sat.sv
// fxp_scale_rnd_sat: x * 1/sqrt2 in fixed point, rounded half away from zero, saturated to DATA_W.
module fxp_scale_rnd_sat
  import iqft3_pipelined_pkg::*;
(
  input  wide_t x,
  output amp_t  y
);
  localparam int PW = DATA_W + 8;
  typedef logic signed [PW-1:0] prod_t;
  localparam prod_t HALF = prod_t'(2 ** (FRAC_W - 1));
  prod_t p, m, q, r;
  always_comb begin
    p = prod_t'(x) * prod_t'(INV_SQRT2);
    m = p[PW-1] ? -p : p;
    q = (m + HALF) >>> FRAC_W;
    r = p[PW-1] ? -q : q;
    y = r > prod_t'(SAT_MAX) ? amp_t'(SAT_MAX) : r < prod_t'(SAT_MIN) ? amp_t'(SAT_MIN) : amp_t'(r);
  end
endmodule

// File: rtl/iqft3_pipelined.sv
// iqft3_pipelined: 14-register streaming 3-qubit inverse QFT with valid/ready and whole-pipeline stall.
module iqft3_pipelined
  import iqft3_pipelined_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] i000_r, i000_i, i001_r, i001_i, i010_r, i010_i, i011_r, i011_i,
  input  logic [DATA_W-1:0] i100_r, i100_i, i101_r, i101_i, i110_r, i110_i, i111_r, i111_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] f000_r, f000_i, f001_r, f001_i, f010_r, f010_i, f011_r, f011_i,
  output logic [DATA_W-1:0] f100_r, f100_i, f101_r, f101_i, f110_r, f110_i, f111_r, f111_i
);
  logic [STAGES-1:0] v;
  logic en;
  vec_t in_vec, st0, sw, st1;
  vec_t vs [0:6];
  assign out_valid = v[STAGES-1];
  assign en = !out_valid || out_ready;
  assign in_ready = en;
  assign in_vec = {i111_r, i111_i, i110_r, i110_i, i101_r, i101_i, i100_r, i100_i,
                   i011_r, i011_i, i010_r, i010_i, i001_r, i001_i, i000_r, i000_i};
  assign {f111_r, f111_i, f110_r, f110_i, f101_r, f101_i, f100_r, f100_i,
          f011_r, f011_i, f010_r, f010_i, f001_r, f001_i, f000_r, f000_i} = vs[6];
  assign vs[0] = st1;
  always_comb
    for (int k = 0; k < 8; k++) sw[k] = st0[swap_idx(3'(k))];
  // data banks load only behind a valid token so f* keeps its last result across bubbles
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      v <= '0;
      st0 <= '0;
      st1 <= '0;
    end else if (en) begin
      v <= {v[STAGES-2:0], in_valid};
      if (in_valid) st0 <= in_vec;
      if (v[0]) st1 <= sw;
    end
  for (genvar g = 0; g < 6; g++) begin : gate
    localparam gate_e OP = gate_op(g);
    localparam logic [2:0] M = gate_mask(g);
    wvec_t q1;
    vec_t q2, sc, nx;
    for (genvar k = 0; k < 8; k++) begin : lane
      fxp_scale_rnd_sat u_r (.x(q1[k].r), .y(sc[k].r));
      fxp_scale_rnd_sat u_i (.x(q1[k].i), .y(sc[k].i));
      assign nx[k] = scaled(OP, M, 3'(k)) ? sc[k] : {q1[k].r[DATA_W-1:0], q1[k].i[DATA_W-1:0]};
    end
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        q1 <= '0;
        q2 <= '0;
      end else if (en) begin
        if (v[2*g+1]) q1 <= rotate(vs[g], OP, M);
        if (v[2*g+2]) q2 <= nx;
      end
    assign vs[g+1] = q2;
  end
endmodule

// File: tb/tb_iqft3_pipelined.sv
// tb_iqft3_pipelined: randomized and directed checks of the inverse QFT pipeline against a behavioural model.
module tb_iqft3_pipelined;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 1;
  logic in_ready, out_valid;
  logic [127:0] din = '0;
  wire [127:0] dout;
  int checks = 0, passed = 0;
  logic [127:0] expq[$];
  logic [127:0] ins[3], exps[3];
  int mr[8], mi[8];

  always #5 clk = ~clk;

  iqft3_pipelined dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .i000_r(din[15:8]), .i000_i(din[7:0]), .i001_r(din[31:24]), .i001_i(din[23:16]),
    .i010_r(din[47:40]), .i010_i(din[39:32]), .i011_r(din[63:56]), .i011_i(din[55:48]),
    .i100_r(din[79:72]), .i100_i(din[71:64]), .i101_r(din[95:88]), .i101_i(din[87:80]),
    .i110_r(din[111:104]), .i110_i(din[103:96]), .i111_r(din[127:120]), .i111_i(din[119:112]),
    .out_valid(out_valid), .out_ready(out_ready),
    .f000_r(dout[15:8]), .f000_i(dout[7:0]), .f001_r(dout[31:24]), .f001_i(dout[23:16]),
    .f010_r(dout[47:40]), .f010_i(dout[39:32]), .f011_r(dout[63:56]), .f011_i(dout[55:48]),
    .f100_r(dout[79:72]), .f100_i(dout[71:64]), .f101_r(dout[95:88]), .f101_i(dout[87:80]),
    .f110_r(dout[111:104]), .f110_i(dout[103:96]), .f111_r(dout[127:120]), .f111_i(dout[119:112])
  );

  function automatic int clamp(int x);
    return x > 127 ? 127 : x < -128 ? -128 : x;
  endfunction

  // multiply by 1/sqrt2 = 11/16, round half away from zero, saturate
  function automatic int rs(int x);
    int p, q;
    p = x * 11;
    q = ((p < 0 ? -p : p) + 8) / 16;
    return clamp(p < 0 ? -q : q);
  endfunction

  function automatic void h(int b);
    int ar, ai, br, bi;
    for (int k = 0; k < 8; k++)
      if ((k & b) == 0) begin
        ar = mr[k]; ai = mi[k]; br = mr[k | b]; bi = mi[k | b];
        mr[k] = rs(ar + br); mi[k] = rs(ai + bi);
        mr[k | b] = rs(ar - br); mi[k | b] = rs(ai - bi);
      end
  endfunction

  // phase e^{-i pi/2}: multiply by -i
  function automatic void cp_half(int mask);
    int t;
    for (int k = 0; k < 8; k++)
      if ((k & mask) == mask) begin
        t = mr[k]; mr[k] = mi[k]; mi[k] = clamp(-t);
      end
  endfunction

  // phase e^{-i pi/4}: multiply by (1 - i)/sqrt2
  function automatic void cp_quarter(int mask);
    int t;
    for (int k = 0; k < 8; k++)
      if ((k & mask) == mask) begin
        t = mr[k]; mr[k] = rs(t + mi[k]); mi[k] = rs(mi[k] - t);
      end
  endfunction

  function automatic logic [127:0] model(logic [127:0] v);
    logic [127:0] o;
    int src;
    for (int k = 0; k < 8; k++) begin
      src = ((k & 1) << 2) | (k & 2) | (k >> 2);
      mr[k] = int'($signed(v[16*src+8 +: 8]));
      mi[k] = int'($signed(v[16*src +: 8]));
    end
    h(1); cp_half(3); h(2); cp_quarter(5); cp_half(6); h(4);
    for (int k = 0; k < 8; k++) begin
      o[16*k+8 +: 8] = 8'(mr[k]);
      o[16*k +: 8] = 8'(mi[k]);
    end
    return o;
  endfunction

  function automatic logic [127:0] pk(input int r[8], input int i[8]);
    logic [127:0] o;
    for (int k = 0; k < 8; k++) begin
      o[16*k+8 +: 8] = 8'(r[k]);
      o[16*k +: 8] = 8'(i[k]);
    end
    return o;
  endfunction

  function automatic logic [127:0] basis(int k, int r, int i);
    logic [127:0] o;
    o = '0;
    o[16*k+8 +: 8] = 8'(r);
    o[16*k +: 8] = 8'(i);
    return o;
  endfunction

  function automatic logic [127:0] rand_vec();
    logic [127:0] o;
    logic full;
    full = $urandom_range(0, 1) == 1;
    for (int b = 0; b < 16; b++)
      o[8*b +: 8] = full ? 8'($urandom) : 8'($urandom_range(0, 40) - 20);
    return o;
  endfunction

  // one handshake cycle: drive, then report an output transfer with its expected value
  task automatic cycle(input logic iv, input logic [127:0] d, input logic ordy,
                       output logic hs, output logic [127:0] got, output logic [127:0] exp);
    @(negedge clk);
    in_valid = iv; din = d; out_ready = ordy;
    #1;
    hs = out_valid && out_ready;
    got = dout;
    exp = '0;
    if (hs) begin
      if (expq.size() > 0) exp = expq.pop_front();
      else exp = 'x;
    end
    if (in_valid && in_ready) expq.push_back(model(d));
  endtask

  task automatic setup_vectors();
    int r1[8], i0[8], r2[8], r3[8], i3[8];
    r1 = '{6, 6, 6, 6, 6, 6, 6, 6};
    i0 = '{0, 0, 0, 0, 0, 0, 0, 0};
    r2 = '{6, -6, 6, -6, 6, -6, 6, -6};
    r3 = '{6, 4, 0, -4, -6, -4, 0, 4};
    i3 = '{0, -4, -6, -4, 0, 4, 6, 4};
    ins[0] = basis(0, 16, 0); ins[1] = basis(4, 16, 0); ins[2] = basis(1, 16, 0);
    exps[0] = pk(r1, i0); exps[1] = pk(r2, i0); exps[2] = pk(r3, i3);
  endtask

  task automatic test_reset();
    rst = 1; in_valid = 0; out_ready = 1; din = '0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else passed++;
    checks++; if (dout !== '0) $display("FAIL reset_f: got %h want 0", dout); else passed++;
    checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else passed++;
    rst = 0;
  endtask

  task automatic test_basis();
    logic hs;
    logic [127:0] got, exp;
    int first, cnt;
    for (int t = 0; t < 3; t++) begin
      first = -1; cnt = 0;
      cycle(1, ins[t], 1, hs, got, exp);
      for (int j = 1; j <= 30; j++) begin
        cycle(0, '0, 1, hs, got, exp);
        if (hs) begin
          cnt++;
          if (first < 0) first = j;
          checks++; if (got !== exps[t]) $display("FAIL basis%0d_value: got %h want %h", t, got, exps[t]); else passed++;
          checks++; if (got !== exp) $display("FAIL basis%0d_model: got %h want %h", t, got, exp); else passed++;
        end
      end
      checks++; if (first != 14) $display("FAIL basis%0d_latency: got %0d want 14", t, first); else passed++;
      checks++; if (cnt != 1) $display("FAIL basis%0d_count: got %0d want 1", t, cnt); else passed++;
    end
  endtask

  task automatic test_back_to_back();
    logic hs, iv, ordy;
    logic [127:0] got, exp, d, d4;
    int first, n, lo;
    first = -1; n = 0; lo = 0;
    d4 = rand_vec();
    for (int j = 0; j < 46; j++) begin
      iv = j < 3 || (j >= 14 && j <= 19);
      d = j < 3 ? ins[j] : d4;
      ordy = !(j >= 14 && j <= 18);
      cycle(iv, d, ordy, hs, got, exp);
      if (!ordy && out_valid && !in_ready) lo++;
      if (hs) begin
        if (first < 0) first = j;
        if (n < 3) begin
          checks++; if (got !== exps[n]) $display("FAIL b2b_order%0d: got %h want %h", n, got, exps[n]); else passed++;
        end
        checks++; if (got !== exp) $display("FAIL b2b_model%0d: got %h want %h", n, got, exp); else passed++;
        n++;
      end
    end
    checks++; if (first != 19) $display("FAIL b2b_first_latency: got %0d want 19", first); else passed++;
    checks++; if (lo != 5) $display("FAIL b2b_in_ready_stall: got %0d low cycles want 5", lo); else passed++;
    checks++; if (n != 4) $display("FAIL b2b_count: got %0d want 4", n); else passed++;
  endtask

  task automatic test_random();
    logic hs;
    logic [127:0] got, exp;
    int n, bad;
    n = 0; bad = 0;
    for (int j = 0; j < 300; j++) begin
      cycle($urandom_range(0, 3) != 0, rand_vec(), $urandom_range(0, 3) != 0, hs, got, exp);
      if (hs) begin
        n++;
        checks++; if (got !== exp) $display("FAIL random_result%0d: got %h want %h", n, got, exp); else passed++;
      end
    end
    for (int j = 0; j < 100 && expq.size() > 0; j++) begin
      cycle(0, '0, 1, hs, got, exp);
      if (hs) begin
        n++;
        checks++; if (got !== exp) $display("FAIL random_drain%0d: got %h want %h", n, got, exp); else passed++;
      end
    end
    checks++; if (expq.size() != 0) $display("FAIL random_drained: got %0d pending want 0", expq.size()); else passed++;
  endtask

  task automatic test_saturation();
    logic hs;
    logic [127:0] got, exp;
    logic [127:0] v[3];
    int n, neg;
    v[0] = basis(0, 127, 127) | basis(4, 127, 127);
    v[1] = '0;
    for (int k = 0; k < 8; k++) v[1] |= basis(k, -128, -128);
    v[2] = basis(3, -128, -128) | basis(7, 127, -128);
    for (int t = 0; t < 3; t++) begin
      n = 0;
      for (int j = 0; j < 30; j++) begin
        cycle(j == 0, v[t], 1, hs, got, exp);
        if (hs) begin
          n++;
          checks++; if (got !== exp) $display("FAIL sat%0d_value: got %h want %h", t, got, exp); else passed++;
          if (t == 0) begin
            neg = 0;
            for (int b = 0; b < 16; b++) neg += int'(got[8*b+7]);
            checks++; if (neg != 0) $display("FAIL sat0_sign: got %0d negative fields want 0", neg); else passed++;
          end
        end
      end
      checks++; if (n != 1) $display("FAIL sat%0d_count: got %0d want 1", t, n); else passed++;
    end
  endtask

  task automatic test_reset_midstream();
    logic hs;
    logic [127:0] got, exp;
    int n, first;
    for (int j = 0; j < 8; j++) cycle(j < 3, rand_vec(), 1, hs, got, exp);
    rst = 1;
    #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL midrst_out_valid: got %b want 0", out_valid); else passed++;
    checks++; if (dout !== '0) $display("FAIL midrst_f: got %h want 0", dout); else passed++;
    checks++; if (in_ready !== 1'b1) $display("FAIL midrst_in_ready: got %b want 1", in_ready); else passed++;
    expq.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    n = 0;
    for (int j = 0; j < 20; j++) begin
      cycle(0, '0, 1, hs, got, exp);
      if (hs) n++;
    end
    checks++; if (n != 0) $display("FAIL midrst_stale: got %0d outputs want 0", n); else passed++;
    first = -1;
    for (int j = 0; j < 30; j++) begin
      cycle(j == 0, ins[0], 1, hs, got, exp);
      if (hs && first < 0) begin
        first = j;
        checks++; if (got !== exps[0]) $display("FAIL midrst_fresh: got %h want %h", got, exps[0]); else passed++;
      end
    end
    checks++; if (first != 14) $display("FAIL midrst_latency: got %0d want 14", first); else passed++;
  endtask

  initial begin
    setup_vectors();
    test_reset();
    test_basis();
    test_back_to_back();
    test_random();
    test_saturation();
    test_reset_midstream();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
